des_decrypt_key_schedule: RTL and testbench
===========================================

# des_decrypt_key_schedule

Iterative DES key-schedule generator for the decryption direction of the Feistel datapath. It accepts a 64-bit key and presents the sixteen 48-bit round subkeys in reverse order, K16 first and K1 last. Consumption is one subkey per ADVANCE strobe from the round controller. It feeds the S-box/permutation/XOR round logic when that logic runs a ciphertext block back to plaintext.

## Interface
- No parameters; all widths fixed by FIPS 46-3.
- CLK  input  1  sole clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- KEY  input  [64:1]  DES key. DES bit n is at index 65-n, so KEY[64] is DES bit 1. Parity bits (DES 8,16,…,64) are ignored.
- LOAD  input  1  one-cycle strobe that samples KEY and starts a new schedule.
- ADVANCE  input  1  one-cycle strobe requesting the next round's subkey.
- SUBKEY  output  [48:1]  current subkey; SUBKEY[48] is DES subkey bit 1.
- ROUND  output  [4:0]  current decryption round, 1..16; 0 when idle.
- KEY_VALID  output  1  high while SUBKEY holds a valid round key.
- DONE  output  1  one-cycle pulse after round 16 is consumed.

## Operation
- Internal state: 28-bit C and D registers, 5-bit round counter, FSM with states IDLE and RUN.
- LOAD, from either state: {C,D} <= PC-1(KEY), ROUND <= 1, state <= RUN.
  - No rotation is applied. C16 = C0 and D16 = D0 because the total encryption left-shift is 28.
  - Round 1 therefore presents K16 = PC-2(C0,D0).
- ADVANCE in RUN with ROUND < 16:
  - C and D each rotate right by R(ROUND+1), then ROUND increments.
  - Right-rotate table, indexed by decryption round 1..16: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decryption round r then presents K(17-r).
- ADVANCE in RUN with ROUND = 16: state <= IDLE, ROUND <= 0, DONE pulses, C/D hold.
- ADVANCE in IDLE is ignored.
- LOAD and ADVANCE in the same cycle: LOAD wins and ADVANCE is discarded. This also applies mid-schedule, where the restart is immediate.
- LOAD on the same cycle as the round-16 ADVANCE: restart to round 1, no DONE pulse.
- SUBKEY = PC-2(C,D) when KEY_VALID = 1, else 48'h0. It is combinational from the registers, with no extra register stage.
- KEY_VALID = (state == RUN).
- Rotation is modulo 28 within C and within D independently; bits never cross between the halves.

## Timing
- Reset values: state IDLE, C = D = 0, ROUND = 0, KEY_VALID = 0, DONE = 0, SUBKEY = 0.
- Reset is asynchronous: asserting RESET mid-schedule forces these values immediately, without waiting for a clock edge.
- LOAD at edge n: KEY_VALID = 1, ROUND = 1 and SUBKEY = K16 are valid after edge n, so the round logic can use them in cycle n+1.
- ADVANCE at edge m: the new ROUND and SUBKEY are valid after edge m. This gives one subkey per cycle at full rate.
- Fastest full schedule: LOAD plus 16 consecutive ADVANCE cycles.
  - After the 16th ADVANCE edge, DONE = 1 for exactly one cycle, and KEY_VALID and ROUND fall to 0 on that same edge.
- KEY is sampled only on the LOAD edge. Later changes to KEY have no effect.
- All outputs are glitch-free registered functions, except SUBKEY, which is PC-2 wiring of registers.

## Test plan
- Reset: hold RESET with random KEY/LOAD/ADVANCE -> SUBKEY = 0, ROUND = 0, KEY_VALID = 0, DONE = 0 throughout.
- Known-answer: LOAD KEY = 64'h133457799BBCDFF1, then ADVANCE each cycle.
  - Round 1 SUBKEY = 48'hCB3D8B0E17F5 (K16).
  - Round 2 = 48'hBF918D3D3F0A (K15).
  - Round 16 = 48'h1B02EFFC7072 (K1).
  - One DONE pulse follows round 16, then IDLE.
- Stalled advance: same key with ADVANCE gaps of 0–5 idle cycles -> SUBKEY and ROUND hold between strobes; the sequence is identical to the known-answer case.
- Mid-schedule reload: at ROUND = 7, assert LOAD together with ADVANCE using KEY = 64'h0 -> next cycle ROUND = 1, SUBKEY = 48'h0, no DONE.
- Ignored strobes and parity: ADVANCE in IDLE -> no output change. Flipping only the parity bits of KEY -> identical subkey sequence.
- Async reset: assert RESET between edges at ROUND = 10 -> outputs clear before the next CLK edge; after release, ADVANCE does nothing until LOAD.

Source files
------------

// File: rtl/des_decrypt_key_schedule.sv
// Iterative DES decryption key schedule: presents K16 down to K1, one subkey per
// ADVANCE strobe, by right-rotating the PC-1 halves from C16/D16 (= C0/D0).
module des_decrypt_key_schedule (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [64:1] KEY,
  input  logic        LOAD,
  input  logic        ADVANCE,
  output logic [48:1] SUBKEY,
  output logic [4:0]  ROUND,
  output logic        KEY_VALID,
  output logic        DONE
);

  typedef enum logic {IDLE, RUN} state_t;

  // Tables list the source DES bit number (1-based) for each output bit in order.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state, state_d;
  logic [28:1] c_q, d_q;
  logic [4:0]  round_q;
  logic        done_q;

  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(56 - i)] = k[7'(65 - PC1[i])];
    return r;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(48 - i)] = cd[6'(57 - PC2[i])];
    return r;
  endfunction

  // DES bit 1 sits at the MSB, so a DES right rotation moves the LSB to the top.
  function automatic logic [28:1] rotr(input logic [28:1] x, input logic single);
    return single ? {x[1], x[28:2]} : {x[2:1], x[28:3]};
  endfunction

  // Rounds 2, 9 and 16 undo the single-bit encryption shifts; all others undo two.
  function automatic logic single_step(input logic [4:0] next_round);
    return (next_round == 5'd2) || (next_round == 5'd9) || (next_round == 5'd16);
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state;
    if (LOAD)
      state_d = RUN;
    else if (ADVANCE && state == RUN && round_q == 5'd16)
      state_d = IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else if (LOAD) begin
      {c_q, d_q} <= pc1(KEY);
      round_q    <= 5'd1;
      done_q     <= 1'b0;
    end else if (ADVANCE && state == RUN) begin
      if (round_q == 5'd16) begin
        round_q <= '0;
        done_q  <= 1'b1;
      end else begin
        c_q     <= rotr(c_q, single_step(round_q + 5'd1));
        d_q     <= rotr(d_q, single_step(round_q + 5'd1));
        round_q <= round_q + 5'd1;
        done_q  <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  always_comb begin
    KEY_VALID = (state == RUN);
    ROUND     = round_q;
    DONE      = done_q;
    SUBKEY    = KEY_VALID ? pc2({c_q, d_q}) : 48'h0;
  end

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// Scoreboard bench for des_decrypt_key_schedule: stimulus queues the expected
// round/subkey/done after each edge, a negedge monitor checks whatever the DUT shows.
module tb_des_decrypt_key_schedule;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [64:1] KEY;
  logic        LOAD;
  logic        ADVANCE;
  logic [48:1] SUBKEY;
  logic [4:0]  ROUND;
  logic        KEY_VALID;
  logic        DONE;

  des_decrypt_key_schedule dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .KEY       (KEY),
    .LOAD      (LOAD),
    .ADVANCE   (ADVANCE),
    .SUBKEY    (SUBKEY),
    .ROUND     (ROUND),
    .KEY_VALID (KEY_VALID),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  round;
    logic [47:0] subkey;
    logic        done;
  } exp_t;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY  = 64'h0101010101010101;

  // Subkey presented at decryption round r is kat[r-1] = K(17-r).
  logic [47:0] kat [16] = '{
    48'hCB3D8B0E17F5, 48'hBF918D3D3F0A, 48'h5F43B7F2E73A, 48'h97C5D1FABA41,
    48'h7571F59467E9, 48'h215FD3DED386, 48'hB1F347BA464F, 48'hE0DBEBEDE781,
    48'hF78A3AC13BFB, 48'hEC84B7F618BC, 48'h63A53E507B2F, 48'h7CEC07EB53A8,
    48'h72ADD6DB351D, 48'h55FC8A42CF99, 48'h79AED9DBC9E5, 48'h1B02EFFC7072
  };

  exp_t sb [$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   m_round = 0;
  logic m_zero  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {9'b0, ROUND, KEY_VALID, DONE, SUBKEY}, 64'h0);
  endtask

  // One clock of stimulus; kz marks that the key being loaded is all zeros.
  task automatic drive(input logic ld, input logic adv, input logic kz);
    exp_t e;
    logic done_e;
    LOAD    = ld;
    ADVANCE = adv;
    done_e  = 1'b0;
    if (ld) begin
      m_round = 1;
      m_zero  = kz;
    end else if (adv && m_round != 0) begin
      if (m_round == 16) begin
        m_round = 0;
        done_e  = 1'b1;
      end else begin
        m_round++;
      end
    end
    if (m_round != 0 || done_e) begin
      e.round  = 5'(m_round);
      e.subkey = (m_round == 0 || m_zero) ? 48'h0 : kat[m_round - 1];
      e.done   = done_e;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    LOAD    = 1'b0;
    ADVANCE = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (KEY_VALID || DONE) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: round=%0d valid=%b done=%b subkey=%h, none expected at %0t",
                 ROUND, KEY_VALID, DONE, SUBKEY, $time);
      end else begin
        e = sb.pop_front();
        check("round",     {59'b0, ROUND},     {59'b0, e.round});
        check("subkey",    {16'b0, SUBKEY},    {16'b0, e.subkey});
        check("key_valid", {63'b0, KEY_VALID}, {63'b0, (e.round != 5'd0)});
        check("done",      {63'b0, DONE},      {63'b0, e.done});
      end
    end
  end

  initial begin
    #400000;
    n_vec++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    RESET = 1'b1; LOAD = 1'b0; ADVANCE = 1'b0; KEY = '0;

    // Reset held against random activity.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      KEY = {$urandom, $urandom}; LOAD = 1'($urandom); ADVANCE = 1'($urandom);
      #1 check_idle("reset_hold");
    end
    @(negedge CLK);
    LOAD = 1'b0; ADVANCE = 1'b0; RESET = 1'b0;
    @(posedge CLK); #1;
    check_idle("after_reset");

    // Known-answer at full rate, then ignored ADVANCE in IDLE.
    KEY = KAT_KEY;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_idle("idle_after_done");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check_idle("advance_in_idle");
    end

    // Parity-flipped key, stalled strobes, KEY changed after LOAD.
    KEY = KAT_KEY ^ PARITY;
    drive(1'b1, 1'b0, 1'b0);
    KEY = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int r = 1; r <= 16; r++) begin
      repeat (r % 6) drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    check_idle("idle_after_stalled");

    // Mid-schedule reload at round 7 with a zero key, LOAD beating ADVANCE.
    KEY = KAT_KEY;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0);
    KEY = 64'h0;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // LOAD coincident with the round-16 ADVANCE: restart, no DONE.
    KEY = KAT_KEY;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0);

    // Asynchronous reset at round 10, between clock edges.
    @(negedge CLK); #1;
    RESET   = 1'b1;
    m_round = 0;
    #1 check_idle("async_reset_immediate");
    @(posedge CLK); #1;
    check_idle("async_reset_held");
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check_idle("advance_after_reset");
    end
    KEY = KAT_KEY;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_idle("final_idle");

    repeat (2) @(posedge CLK);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
